// File: rtl/dmem_access.sv
// Load/store stage: drives a valid/ready data bus, steers store lanes, aligns and extends load data.
// Latency: store 2 cycles, load 3 cycles from accept with zero-wait memory; each ready/rsp wait cycle adds one.
// Backpressure: stall_o holds upstream while a request is pending or awaiting response; released in DONE.
module dmem_access #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              valid_i,
    input  logic              memread_i,
    input  logic              memwrite_i,
    input  logic [2:0]        funct3_i,
    input  logic [AWIDTH-1:0] addr_i,
    input  logic [DWIDTH-1:0] store_data_i,
    output logic              stall_o,
    output logic              done_o,
    output logic              fault_o,
    output logic [DWIDTH-1:0] memory_data_o,
    output logic              req_valid_o,
    input  logic              req_ready_i,
    output logic              req_we_o,
    output logic [AWIDTH-1:0] req_addr_o,
    output logic [3:0]        req_be_o,
    output logic [DWIDTH-1:0] req_wdata_o,
    input  logic              rsp_valid_i,
    input  logic [DWIDTH-1:0] rsp_rdata_i
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t            state, state_nxt;
    logic              mem_op, legal, misaligned, accept;
    logic [1:0]        off;
    logic [1:0]        off_q;
    logic [2:0]        funct3_q;
    logic [3:0]        st_be;
    logic [DWIDTH-1:0] st_wdata;
    logic [DWIDTH-1:0] shifted;
    logic [DWIDTH-1:0] ld_data;

    assign mem_op = valid_i && (memread_i || memwrite_i);
    assign off    = addr_i[1:0];

    always_comb begin
        legal = 1'b0;
        if (memwrite_i) begin
            legal = (funct3_i == 3'b000) || (funct3_i == 3'b001) || (funct3_i == 3'b010);
        end else begin
            case (funct3_i)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
                default:                                legal = 1'b0;
            endcase
        end
    end

    assign misaligned = ((funct3_i[1:0] == 2'b01) && off[0]) ||
                        ((funct3_i[1:0] == 2'b10) && (off != 2'b00));
    assign accept     = (state == S_IDLE) && mem_op && legal && !misaligned;

    // funct3[1:0] encodes access size for both loads and stores
    always_comb begin
        st_wdata = store_data_i;
        st_be    = 4'b1111;
        case (funct3_i[1:0])
            2'b00: begin
                st_wdata = {4{store_data_i[7:0]}};
                st_be    = 4'b0001 << off;
            end
            2'b01: begin
                st_wdata = {2{store_data_i[15:0]}};
                st_be    = 4'b0011 << off;
            end
            default: begin
                st_wdata = store_data_i;
                st_be    = 4'b1111;
            end
        endcase
    end

    assign shifted = rsp_rdata_i >> {off_q, 3'b000};

    always_comb begin
        ld_data = shifted;
        case (funct3_q)
            3'b000:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  ld_data = {24'b0, shifted[7:0]};
            3'b101:  ld_data = {16'b0, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept)      state_nxt = S_REQ;
            S_REQ:  if (req_ready_i) state_nxt = req_we_o ? S_DONE : S_WAIT;
            S_WAIT: if (rsp_valid_i) state_nxt = S_DONE;
            S_DONE:                  state_nxt = S_IDLE;
            default:                 state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_valid_o = (state == S_REQ);
        done_o      = (state == S_DONE);
        stall_o     = (state == S_REQ) || (state == S_WAIT) || accept;
        fault_o     = (state == S_IDLE) && mem_op && !(legal && !misaligned);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_addr_o    <= '0;
            req_we_o      <= 1'b0;
            req_be_o      <= 4'b0;
            req_wdata_o   <= '0;
            funct3_q      <= 3'b0;
            off_q         <= 2'b0;
            memory_data_o <= '0;
        end else begin
            if (accept) begin
                req_addr_o  <= {addr_i[AWIDTH-1:2], 2'b00};
                req_we_o    <= memwrite_i;
                req_be_o    <= st_be;
                req_wdata_o <= st_wdata;
                funct3_q    <= funct3_i;
                off_q       <= off;
            end
            if ((state == S_WAIT) && rsp_valid_i) begin
                memory_data_o <= ld_data;
            end
        end
    end

endmodule
